// File: rtl/sm_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, centre-of-bit sampling, one-cycle valid/frameErr pulses.
// After a bad stop bit the line must return high before another start edge is accepted.
module sm_uart_rx #(
  parameter int unsigned BAUD_DIV = 868
) (
  input  logic       clkIn,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frameErr,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(BAUD_DIV);
  localparam logic [CntW-1:0] HalfLast = CntW'(BAUD_DIV / 2 - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(BAUD_DIV - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  localparam logic [2:0] StWaitIdle = 3'd0;
  localparam logic [2:0] StIdle     = 3'd1;
  localparam logic [2:0] StStart    = 3'd2;
  localparam logic [2:0] StData     = 3'd3;
  localparam logic [2:0] StStop     = 3'd4;

  logic            rxMeta;
  logic            rxS;
  logic [1:0]      syncFill;
  logic [2:0]      stateQ, stateD;
  logic [CntW-1:0] cntQ, cntD;
  logic [2:0]      bitIdxQ, bitIdxD;
  logic [7:0]      shiftQ, shiftD;
  logic [7:0]      dataQ, dataD;
  logic            validQ, validD;
  logic            frameErrQ, frameErrD;

  // Synchronizer flops reset high so a held-low line never looks like a start edge.
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      rxMeta <= 1'b1;
      rxS    <= 1'b1;
    end else begin
      rxMeta <= rx;
      rxS    <= rxMeta;
    end
  end

  // rxS only reflects the real line once both flops have been refilled after reset.
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      syncFill <= 2'b00;
    end else begin
      syncFill <= {syncFill[0], 1'b1};
    end
  end

  always_comb begin
    stateD    = stateQ;
    cntD      = cntQ;
    bitIdxD   = bitIdxQ;
    shiftD    = shiftQ;
    dataD     = dataQ;
    validD    = 1'b0;
    frameErrD = 1'b0;
    case (stateQ)
      StWaitIdle: begin
        if (syncFill[1] && rxS) begin
          stateD = StIdle;
        end
      end
      StIdle: begin
        if (!rxS) begin
          stateD = StStart;
          cntD   = '0;
        end
      end
      StStart: begin
        if (cntQ == HalfLast) begin
          cntD    = '0;
          bitIdxD = 3'd0;
          stateD  = rxS ? StIdle : StData;
        end else begin
          cntD = cntQ + CntOne;
        end
      end
      StData: begin
        if (cntQ == BitLast) begin
          cntD            = '0;
          shiftD[bitIdxQ] = rxS;
          bitIdxD         = bitIdxQ + 3'd1;
          if (bitIdxQ == 3'd7) begin
            stateD = StStop;
          end
        end else begin
          cntD = cntQ + CntOne;
        end
      end
      StStop: begin
        if (cntQ == BitLast) begin
          cntD = '0;
          if (rxS) begin
            dataD  = shiftQ;
            validD = 1'b1;
            stateD = StIdle;
          end else begin
            frameErrD = 1'b1;
            stateD    = StWaitIdle;
          end
        end else begin
          cntD = cntQ + CntOne;
        end
      end
      default: begin
        stateD = StWaitIdle;
        cntD   = '0;
      end
    endcase
  end

  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      stateQ    <= StWaitIdle;
      cntQ      <= '0;
      bitIdxQ   <= 3'd0;
      shiftQ    <= 8'h00;
      dataQ     <= 8'h00;
      validQ    <= 1'b0;
      frameErrQ <= 1'b0;
    end else begin
      stateQ    <= stateD;
      cntQ      <= cntD;
      bitIdxQ   <= bitIdxD;
      shiftQ    <= shiftD;
      dataQ     <= dataD;
      validQ    <= validD;
      frameErrQ <= frameErrD;
    end
  end

  assign data     = dataQ;
  assign valid    = validQ;
  assign frameErr = frameErrQ;
  assign busy     = (stateQ == StStart) || (stateQ == StData) || (stateQ == StStop);

endmodule

// File: tb/tb_sm_uart_rx.sv
// Randomized bench for sm_uart_rx: line-level frame driver plus an event-queue reference model
// predicting each valid/frameErr pulse (time, kind, data) from the start-edge cycle.
module tb_sm_uart_rx;

  localparam int unsigned B   = 16;
  localparam int unsigned Lat = B / 2 + 9 * B + 1 + 2;

  logic       clkIn;
  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frameErr;
  logic       busy;

  sm_uart_rx #(.BAUD_DIV(B)) dut (
    .clkIn   (clkIn),
    .rst_n   (rst_n),
    .rx      (rx),
    .data    (data),
    .valid   (valid),
    .frameErr(frameErr),
    .busy    (busy)
  );

  typedef struct {
    int unsigned cyc;
    bit          isErr;
    logic [7:0]  d;
  } evT;

  evT          expQ[$];
  logic [7:0]  modelData;
  int unsigned cyc;
  int          errCnt;
  int          chkCnt;

  initial clkIn = 1'b0;
  always #5 clkIn = ~clkIn;

  initial cyc = 0;
  always @(posedge clkIn) cyc <= cyc + 1;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: every pulse must match the oldest pending prediction.
  always @(negedge clkIn) begin
    if (rst_n) begin
      if (expQ.size() > 0 && cyc > expQ[0].cyc) begin
        checkEq("missedPulse", cyc, expQ[0].cyc);
        void'(expQ.pop_front());
      end
      if (valid || frameErr) begin
        checkEq("pulseExclusive", 32'(valid & frameErr), 32'd0);
        if (expQ.size() == 0) begin
          checkEq("unexpectedPulse", {30'd0, valid, frameErr}, 32'd0);
        end else begin
          evT e;
          e = expQ.pop_front();
          checkEq("pulseTime", cyc, e.cyc);
          checkEq("pulseKind", 32'(frameErr), 32'(e.isErr));
          if (e.isErr) begin
            checkEq("dataHeld", 32'(data), 32'(modelData));
          end else begin
            checkEq("rxData", 32'(data), 32'(e.d));
            modelData = e.d;
          end
        end
      end
    end
  end

  task automatic hold(input int unsigned n);
    repeat (n) @(posedge clkIn);
    #1;
  endtask

  task automatic sendFrame(input logic [7:0] d, input bit stopOk);
    evT e;
    e.cyc   = cyc + Lat;
    e.isErr = !stopOk;
    e.d     = d;
    expQ.push_back(e);
    rx = 1'b0;
    hold(B);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      hold(B);
    end
    rx = stopOk;
    hold(B);
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 400; i++) begin
      if (expQ.size() == 0) break;
      @(posedge clkIn);
    end
    #1;
    checkEq("drained", expQ.size(), 32'd0);
    expQ.delete();
  endtask

  task automatic applyReset(input int unsigned n);
    rst_n = 1'b0;
    expQ.delete();
    modelData = 8'h00;
    #1;
    checkEq("rstData", 32'(data), 32'h00);
    checkEq("rstBusy", 32'(busy), 32'd0);
    checkEq("rstValid", 32'(valid), 32'd0);
    checkEq("rstFrameErr", 32'(frameErr), 32'd0);
    hold(n);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    bit prevBad;
    errCnt    = 0;
    chkCnt    = 0;
    rx        = 1'b1;
    modelData = 8'h00;
    rst_n     = 1'b1;
    @(posedge clkIn);
    #1;
    applyReset(3);
    hold(2 * B);

    sendFrame(8'h55, 1'b1);
    waitDrain();
    hold(B);

    // Back-to-back frames; predictions are 160 cycles apart by construction.
    sendFrame(8'hA5, 1'b1);
    sendFrame(8'h3C, 1'b1);
    waitDrain();
    hold(B);

    // Short low glitch on the idle line.
    rx = 1'b0;
    hold(3);
    rx   = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clkIn);
      if (busy) seen = 1'b1;
    end
    checkEq("glitchBusySeen", 32'(seen), 32'd1);
    checkEq("glitchBusyDone", 32'(busy), 32'd0);
    checkEq("glitchData", 32'(data), 32'(modelData));
    @(posedge clkIn);
    #1;

    // Bad stop bit, long break, then a good frame.
    sendFrame(8'h0F, 1'b0);
    hold(B);
    checkEq("breakBusy", 32'(busy), 32'd0);
    hold(39 * B);
    checkEq("breakData", 32'(data), 32'(modelData));
    rx = 1'b1;
    hold(B);
    sendFrame(8'h81, 1'b1);
    waitDrain();
    hold(B);

    // Reset in the middle of data bit 4 of 0xFF.
    rx = 1'b0;
    hold(B);
    rx = 1'b1;
    hold(4 * B + B / 2);
    applyReset(3);
    hold(2 * B);
    checkEq("postRstBusy", 32'(busy), 32'd0);
    sendFrame(8'h12, 1'b1);
    waitDrain();
    hold(B);

    // Line held low across reset release.
    rx = 1'b0;
    applyReset(3);
    seen = 1'b0;
    for (int i = 0; i < 3 * B; i++) begin
      @(negedge clkIn);
      if (busy) seen = 1'b1;
    end
    checkEq("lowRelBusy", 32'(seen), 32'd0);
    @(posedge clkIn);
    #1;
    rx = 1'b1;
    hold(B);
    sendFrame(8'hC3, 1'b1);
    waitDrain();

    // Random frames, random gaps (zero gap allowed only after a good stop).
    prevBad = 1'b0;
    for (int n = 0; n < 12; n++) begin
      int unsigned gap;
      logic [7:0]  d;
      bit          ok;
      gap = prevBad ? $urandom_range(3 * B, B) : $urandom_range(2 * B, 0);
      if (gap > 0) begin
        rx = 1'b1;
        hold(gap);
      end
      d  = 8'($urandom);
      ok = ($urandom_range(4, 0) != 0);
      sendFrame(d, ok);
      prevBad = !ok;
    end
    rx = 1'b1;
    hold(B);
    waitDrain();
    checkEq("finalData", 32'(data), 32'(modelData));

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
